// File: rtl/param_stream_out.sv
// param_stream_out: snapshots the network's weight and bias arrays on a start
// request and replays them as a valid/ready word stream. The word order is the
// same as the parameter load file, so a dump can be reloaded unchanged.
module param_stream_out #(
  parameter  int DATA_WIDTH = 32,
  parameter  int L1         = 2,
  parameter  int L2         = 8,
  parameter  int L3         = 8,
  parameter  int L4         = 1,
  localparam int N_WORDS    = L2*L1 + L2 + L3*L2 + L3 + L4*L3 + L4,
  localparam int IDX_W      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [0:L2-1][0:L1-1][DATA_WIDTH-1:0] W1,
  input  logic [0:L3-1][0:L2-1][DATA_WIDTH-1:0] W2,
  input  logic [0:L4-1][0:L3-1][DATA_WIDTH-1:0] W3,
  input  logic [0:L2-1][0:0][DATA_WIDTH-1:0]    b1,
  input  logic [0:L3-1][0:0][DATA_WIDTH-1:0]    b2,
  input  logic [0:L4-1][0:0][DATA_WIDTH-1:0]    b3,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic                                  m_last,
  output logic [IDX_W-1:0]                      m_index,
  output logic [2:0]                            m_section,
  output logic                                  busy,
  output logic                                  done
);

  // First flat index of each section in the load-file order.
  localparam int B_B1 = L2*L1;
  localparam int B_W2 = B_B1 + L2;
  localparam int B_B2 = B_W2 + L3*L2;
  localparam int B_W3 = B_B2 + L3;
  localparam int B_B3 = B_W3 + L4*L3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                              state_q;
  logic [N_WORDS-1:0][DATA_WIDTH-1:0]  snap_q;
  logic [N_WORDS-1:0][DATA_WIDTH-1:0]  flat_s;
  logic [DATA_WIDTH-1:0]               m_data_q;
  logic                                m_valid_q;
  logic                                m_last_q;
  logic [IDX_W-1:0]                    m_index_q;
  logic [2:0]                          m_section_q;
  logic                                busy_q;
  logic                                done_q;
  logic [IDX_W-1:0]                    idx_d;
  logic                                handshake_s;
  logic                                accept_s;

  // Section code (0=W1,1=b1,2=W2,3=b2,4=W3,5=b3) for a flat word index.
  function automatic logic [2:0] section_of(input logic [IDX_W-1:0] idx);
    int v;
    v = int'(32'(idx));
    if (v < B_B1)      section_of = 3'd0;
    else if (v < B_W2) section_of = 3'd1;
    else if (v < B_B2) section_of = 3'd2;
    else if (v < B_W3) section_of = 3'd3;
    else if (v < B_B3) section_of = 3'd4;
    else               section_of = 3'd5;
  endfunction

  assign idx_d       = m_index_q + IDX_W'(1);
  assign handshake_s = m_valid_q & m_ready;
  assign accept_s    = (state_q == S_IDLE) & start;

  // Flatten the live parameter arrays into stream order.
  always_comb begin
    flat_s = '0;
    for (int i = 0; i < L2; i++) begin
      for (int j = 0; j < L1; j++) flat_s[i*L1 + j] = W1[i][j];
      flat_s[B_B1 + i] = b1[i][0];
    end
    for (int i = 0; i < L3; i++) begin
      for (int j = 0; j < L2; j++) flat_s[B_W2 + i*L2 + j] = W2[i][j];
      flat_s[B_B2 + i] = b2[i][0];
    end
    for (int i = 0; i < L4; i++) begin
      for (int j = 0; j < L3; j++) flat_s[B_W3 + i*L3 + j] = W3[i][j];
      flat_s[B_B3 + i] = b3[i][0];
    end
  end

  // Snapshot buffer: captured only when a start is accepted from IDLE.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      snap_q <= flat_s;
    end
  end

  // Stream FSM with all stream outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_index_q   <= '0;
      m_section_q <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Word 0 comes straight from the inputs; the buffer holds the rest.
            state_q     <= S_STREAM;
            m_data_q    <= flat_s[0];
            m_valid_q   <= 1'b1;
            m_index_q   <= '0;
            m_section_q <= section_of('0);
            m_last_q    <= (N_WORDS == 1);
            busy_q      <= 1'b1;
          end
        end
        S_STREAM: begin
          if (handshake_s) begin
            if (m_last_q) begin
              state_q     <= S_DONE;
              m_valid_q   <= 1'b0;
              m_last_q    <= 1'b0;
              m_data_q    <= '0;
              m_index_q   <= '0;
              m_section_q <= 3'd0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              m_index_q   <= idx_d;
              m_data_q    <= snap_q[idx_d];
              m_section_q <= section_of(idx_d);
              m_last_q    <= (idx_d == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          // start is deliberately ignored here; only IDLE accepts it.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign m_index   = m_index_q;
  assign m_section = m_section_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_param_stream_out.sv
// Self-checking bench for param_stream_out: randomized stimulus compared with
// a queue-based reference of the expected word stream in load-file order.
module tb_param_stream_out;

  localparam int DW      = 32;
  localparam int L1      = 2;
  localparam int L2      = 8;
  localparam int L3      = 8;
  localparam int L4      = 1;
  localparam int N_WORDS = 105;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic m_ready;
  logic [0:L2-1][0:L1-1][DW-1:0] W1;
  logic [0:L3-1][0:L2-1][DW-1:0] W2;
  logic [0:L4-1][0:L3-1][DW-1:0] W3;
  logic [0:L2-1][0:0][DW-1:0]    b1;
  logic [0:L3-1][0:0][DW-1:0]    b2;
  logic [0:L4-1][0:0][DW-1:0]    b3;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic [6:0]    m_index;
  logic [2:0]    m_section;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_data[$];
  int            exp_sec[$];

  param_stream_out #(.DATA_WIDTH(DW), .L1(L1), .L2(L2), .L3(L3), .L4(L4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .W1(W1), .W2(W2), .W3(W3), .b1(b1), .b2(b2), .b3(b3),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_index(m_index), .m_section(m_section), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Global watchdog so the bench can never hang.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the expected stream is the load-file order of the arrays.
  task automatic build_expected();
    exp_data.delete();
    exp_sec.delete();
    for (int i = 0; i < L2; i++) for (int j = 0; j < L1; j++) begin exp_data.push_back(W1[i][j]); exp_sec.push_back(0); end
    for (int i = 0; i < L2; i++) begin exp_data.push_back(b1[i][0]); exp_sec.push_back(1); end
    for (int i = 0; i < L3; i++) for (int j = 0; j < L2; j++) begin exp_data.push_back(W2[i][j]); exp_sec.push_back(2); end
    for (int i = 0; i < L3; i++) begin exp_data.push_back(b2[i][0]); exp_sec.push_back(3); end
    for (int i = 0; i < L4; i++) for (int j = 0; j < L3; j++) begin exp_data.push_back(W3[i][j]); exp_sec.push_back(4); end
    for (int i = 0; i < L4; i++) begin exp_data.push_back(b3[i][0]); exp_sec.push_back(5); end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < L2; i++) begin
      for (int j = 0; j < L1; j++) W1[i][j] = 32'h100 * i + j;
      b1[i][0] = 32'h1000 + i;
    end
    for (int i = 0; i < L3; i++) begin
      for (int j = 0; j < L2; j++) W2[i][j] = 32'h2000 + 32'h10 * i + j;
      b2[i][0] = 32'h2800 + i;
    end
    for (int i = 0; i < L4; i++) begin
      for (int j = 0; j < L3; j++) W3[i][j] = 32'h3100 + 32'h10 * i + j;
      b3[i][0] = 32'h3000 + i;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < L2; i++) begin
      for (int j = 0; j < L1; j++) W1[i][j] = $urandom;
      b1[i][0] = $urandom;
    end
    for (int i = 0; i < L3; i++) begin
      for (int j = 0; j < L2; j++) W2[i][j] = $urandom;
      b2[i][0] = $urandom;
    end
    for (int i = 0; i < L4; i++) begin
      for (int j = 0; j < L3; j++) W3[i][j] = $urandom;
      b3[i][0] = $urandom;
    end
  endtask

  task automatic load_zero();
    W1 = '0; W2 = '0; W3 = '0; b1 = '0; b2 = '0; b3 = '0;
  endtask

  // One start/stream/done sequence with optional stalls, mid-stream
  // input corruption plus a second start, negative-word probe and reset abort.
  task automatic run_stream(input bit rand_ready, input int stall_first, input bit corrupt,
                            input int abort_at, input bit neg_check);
    int k = 0;
    int cyc = 0;
    bit rdy;
    bit hit = 1'b0;
    build_expected();
    m_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    while (k < N_WORDS && cyc < 3000) begin
      check("valid", m_valid, 1'b1);
      check("busy", busy, 1'b1);
      check("done_low", done, 1'b0);
      check("index", m_index, k);
      check("data", m_data, exp_data[k]);
      check("section", m_section, exp_sec[k]);
      check("last", m_last, (k == N_WORDS - 1));
      if (neg_check && k == 53) begin
        check("neg_word", m_data, 32'hFFFF_FF80);
        check("neg_section", m_section, 3'd2);
      end
      if (abort_at >= 0 && k == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_valid", m_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_index", m_index, 7'd0);
        repeat (3) begin
          step();
          check("rst_no_done", done, 1'b0);
          check("rst_valid_hold", m_valid, 1'b0);
        end
        reset = 1'b0;
        return;
      end
      if (cyc < stall_first) rdy = 1'b0;
      else if (rand_ready)   rdy = 1'($urandom_range(0, 1));
      else                   rdy = 1'b1;
      if (corrupt && k == 10 && !hit) begin
        hit = 1'b1;
        load_zero();
        start = 1'b1;
      end
      m_ready = rdy;
      step();
      start = 1'b0;
      if (rdy) k++;
      cyc++;
    end
    check("stream_complete", k, N_WORDS);
    check("done_pulse", done, 1'b1);
    check("done_valid_low", m_valid, 1'b0);
    check("done_busy_low", busy, 1'b0);
    // start during the DONE cycle must be ignored
    m_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("idle_done_low", done, 1'b0);
    check("idle_valid", m_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    repeat (2) begin
      step();
      check("idle_stays", m_valid, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    load_zero();
    repeat (2) step();
    check("reset_valid", m_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_last", m_last, 1'b0);
    check("reset_data", m_data, 32'd0);
    check("reset_index", m_index, 7'd0);
    check("reset_section", m_section, 3'd0);
    reset = 1'b0;
    step();

    load_pattern();
    run_stream(1'b0, 0, 1'b0, -1, 1'b0);

    load_pattern();
    W2[3][5] = 32'hFFFF_FF80;
    run_stream(1'b1, 0, 1'b0, -1, 1'b1);

    load_random();
    run_stream(1'b1, 20, 1'b0, -1, 1'b0);

    load_random();
    run_stream(1'b0, 0, 1'b1, -1, 1'b0);

    // inputs were zeroed mid-stream above; this run must stream zeros
    run_stream(1'b0, 0, 1'b0, -1, 1'b0);

    load_random();
    run_stream(1'b0, 0, 1'b0, 40, 1'b0);

    load_random();
    run_stream(1'b1, 0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
